// File: rtl/uc.sv
// rtl/uc.sv - control unit: opcode decode, zero flag, RUN/HALT, illegal flag, retired count
// Controls are combinational from Opcode and state; all state updates on the rising edge.
module uc #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             zflag,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] icount
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic   is_halt;
   logic   is_rsv;

   always_comb begin
      s_inc     = 1'b1;
      s_inm     = 1'b0;
      we3       = 1'b0;
      wez       = 1'b0;
      Op        = 3'b000;
      is_halt   = 1'b0;
      is_rsv    = 1'b0;
      state_nxt = state;
      if (reset) begin
         // PC reset in the datapath dominates; keep everything quiet
         s_inc = 1'b1;
      end else if (state == ST_HALT) begin
         s_inc = 1'b0;
      end else if (!Opcode[5]) begin
         Op  = Opcode[4:2];
         we3 = 1'b1;
         wez = 1'b1;
      end else if (Opcode[4:2] == 3'b000) begin
         we3   = 1'b1;
         s_inm = 1'b1;
      end else begin
         case (Opcode)
            6'b101000: s_inc = 1'b0;
            6'b101001: s_inc = ~zflag;
            6'b101010: s_inc = zflag;
            6'b101111: begin
               s_inc     = 1'b0;
               is_halt   = 1'b1;
               state_nxt = ST_HALT;
            end
            default:   is_rsv = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RUN;
         zflag   <= 1'b0;
         illegal <= 1'b0;
         icount  <= '0;
      end else begin
         state <= state_nxt;
         if (wez)
            zflag <= z;
         if (is_rsv)
            illegal <= 1'b1;
         if (state == ST_RUN)
            icount <= icount + 1'b1;
      end
   end

   assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_uc.sv
// tb/tb_uc.sv - scoreboard bench for uc against a behavioural model
// Two instances share stimulus: default counter width and a 4-bit counter for wrap.
module tb_uc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  Opcode = 6'd0;
   logic        z = 1'b0;

   logic        s_inc, s_inm, we3, wez, zflag, halted, illegal;
   logic [2:0]  Op;
   logic [15:0] icount;
   logic        s_inc4, s_inm4, we34, wez4, zflag4, halted4, illegal4;
   logic [2:0]  Op4;
   logic [3:0]  icount4;

   always #5 clk = ~clk;

   uc #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
      .zflag(zflag), .halted(halted), .illegal(illegal), .icount(icount)
   );

   uc #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
      .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(Op4),
      .zflag(zflag4), .halted(halted4), .illegal(illegal4), .icount(icount4)
   );

   typedef struct {
      string      tag;
      logic       s_inc, s_inm, we3, wez;
      logic [2:0] op;
      logic       zflag, halted, illegal;
      int         count;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // behavioural model state
   bit   m_halted = 0, m_zflag = 0, m_illegal = 0;
   int   m_count = 0;

   task automatic chk(input string name, input string tag, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("s_inc",   e.tag, 16'(s_inc),   16'(e.s_inc));
         chk("s_inm",   e.tag, 16'(s_inm),   16'(e.s_inm));
         chk("we3",     e.tag, 16'(we3),     16'(e.we3));
         chk("wez",     e.tag, 16'(wez),     16'(e.wez));
         chk("Op",      e.tag, 16'(Op),      16'(e.op));
         chk("zflag",   e.tag, 16'(zflag),   16'(e.zflag));
         chk("halted",  e.tag, 16'(halted),  16'(e.halted));
         chk("illegal", e.tag, 16'(illegal), 16'(e.illegal));
         chk("icount",  e.tag, icount,       16'(e.count % 65536));
         chk("icount4", e.tag, 16'(icount4), 16'(e.count % 16));
         chk("halted4", e.tag, 16'(halted4), 16'(e.halted));
      end
   end

   // one instruction cycle: drive, predict, advance model
   task automatic step(input string tag, input bit r, input logic [5:0] opc, input bit zz);
      exp_t e;
      int   v;
      bit   is_alu, is_li, is_halt, is_rsv;
      @(posedge clk);
      #1;
      reset  = r;
      Opcode = opc;
      z      = zz;
      v       = int'(opc);
      is_alu  = v < 32;
      is_li   = v >= 32 && v < 36;
      is_halt = v == 47;
      is_rsv  = !is_alu && !is_li && v != 40 && v != 41 && v != 42 && !is_halt;
      e.tag = tag;
      e.s_inc = 1; e.s_inm = 0; e.we3 = 0; e.wez = 0; e.op = 3'd0;
      e.zflag = m_zflag; e.halted = m_halted; e.illegal = m_illegal; e.count = m_count;
      if (!r && m_halted) begin
         e.s_inc = 0;
      end else if (!r) begin
         if (is_alu) begin
            e.op = 3'(v / 4); e.we3 = 1; e.wez = 1;
         end else if (is_li) begin
            e.we3 = 1; e.s_inm = 1;
         end else if (v == 40 || is_halt) begin
            e.s_inc = 0;
         end else if (v == 41) begin
            e.s_inc = !m_zflag;
         end else if (v == 42) begin
            e.s_inc = m_zflag;
         end
      end
      exp_q.push_back(e);
      if (r) begin
         m_halted = 0; m_zflag = 0; m_illegal = 0; m_count = 0;
      end else if (!m_halted) begin
         m_count++;
         if (is_alu) m_zflag = zz;
         if (is_rsv) m_illegal = 1;
         if (is_halt) m_halted = 1;
      end
   endtask

   initial begin
      logic [5:0] rop;
      // establish a known state before the model takes over
      reset = 1'b1;
      repeat (2) @(posedge clk);

      step("rst", 1, 6'b000001, 0);
      step("rst", 1, 6'b000001, 0);
      step("alu_z1", 0, 6'b001100, 1);
      step("li", 0, 6'b100011, 0);
      step("jz_z1", 0, 6'b101001, 0);
      step("jnz_z1", 0, 6'b101010, 1);
      step("alu_z0", 0, 6'b000111, 0);
      step("jz_z0", 0, 6'b101001, 1);
      step("jnz_z0", 0, 6'b101010, 0);
      step("j", 0, 6'b101000, 0);
      step("rst_halt", 1, 6'b101111, 0);

      for (int i = 0; i < 5; i++) step("pre_halt", 0, 6'(i * 4), i[0]);
      step("halt", 0, 6'b101111, 0);
      for (int i = 0; i < 10; i++) step("in_halt", 0, 6'(i * 3), 1);
      step("rst_pulse", 1, 6'b000000, 0);
      step("after_rst", 0, 6'b100000, 0);

      step("illegal", 0, 6'b110101, 1);
      for (int i = 0; i < 20; i++) step("post_ill", 0, (i % 2) ? 6'b101000 : 6'(i), 1);
      step("rst_ill", 1, 6'b000000, 0);

      for (int i = 0; i < 17; i++) step("wrap", 0, 6'b100100, 0);
      step("wrap_chk", 0, 6'b101000, 0);

      for (int i = 0; i < 400; i++) begin
         rop = 6'($urandom_range(0, 63));
         step("rand", ($urandom_range(0, 29) == 0), rop, 1'($urandom));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uc.md
# uc

Control unit for the single-cycle microcontroller datapath (no data memory). It decodes the 6-bit `Opcode` (instruction bits [15:10]) and drives the datapath controls `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It holds the registered zero flag, a RUN/HALT state machine, a sticky illegal-opcode flag and a retired-instruction counter. It sits beside the datapath: the datapath's `Opcode`/`z` outputs come in here, and the control outputs here go back to the datapath.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `Opcode`  in  6  instruction bits [15:10] from the datapath
- `z`  in  1  combinational ALU zero output from the datapath
- `s_inc`  out  1  1 = PC+1, 0 = jump to instruction[9:0]
- `s_inm`  out  1  1 = write immediate instruction[11:4], 0 = write ALU result
- `we3`  out  1  register-file write enable
- `wez`  out  1  zero-flag load enable (also exported to the datapath)
- `Op`  out  3  ALU operation select
- `zflag`  out  1  registered zero flag
- `halted`  out  1  1 while in HALT state
- `illegal`  out  1  sticky; set by any reserved opcode executed in RUN
- `icount`  out  CNT_W  instructions retired since reset

## Operation
- Decode is combinational from `Opcode` and state. Defaults are `s_inc`=1, `s_inm`=0, `we3`=0, `wez`=0, `Op`=0.
- **ALU** (`Opcode[5]`=0):
  - `Op`=`Opcode[4:2]`, `we3`=1, `wez`=1.
  - `Opcode[1:0]` are register-address bits and are ignored.
- **LI** (`Opcode[5:2]`=1000): `we3`=1, `s_inm`=1, `wez`=0. `Opcode[1:0]` are immediate bits and are ignored.
- **J** (101000): `s_inc`=0.
- **JZ** (101001): `s_inc`=`~zflag`.
- **JNZ** (101010): `s_inc`=`zflag`.
- **HALT** (101111):
  - `s_inc`=0. The assembler encodes the instruction's own address in [9:0], so the PC freezes.
  - Next state is HALT.
- **Reserved**: all other opcodes (1001xx, 101011–101110, 11xxxx).
  - Executed as NOP: defaults apply.
  - `illegal` is set on the next edge.
- **Zero flag**: `zflag` loads `z` on an edge where `wez`=1. Otherwise it holds. Jumps read the registered `zflag`, never the live `z`.
- **State machine**:
  - RUN → HALT on a decoded HALT.
  - HALT → HALT until `reset`.
  - While in HALT, outputs are forced to `s_inc`=0, `we3`=0, `wez`=0, `s_inm`=0, `Op`=0, whatever `Opcode` is.
- **icount**:
  - +1 per edge in RUN, including the HALT instruction's cycle.
  - Frozen in HALT.
  - Wraps modulo 2^CNT_W.
- **illegal**: set only in RUN. Cleared only by `reset`.

## Timing
- Decode has zero latency: controls are valid in the same cycle as `Opcode`.
- Registered updates (`zflag`, state, `illegal`, `icount`) are visible the cycle after the triggering instruction.
- ALU then JZ back-to-back: the JZ sees the flag produced by the ALU instruction.
- Reset values after the edge with `reset`=1:
  - state RUN, `zflag`=0, `illegal`=0, `icount`=0, `halted`=0.
- While `reset`=1, outputs are forced to `we3`=0, `wez`=0, `s_inc`=1, `s_inm`=0, `Op`=0. The PC reset in the datapath dominates.
- Reset has priority over every other event, including a HALT or ALU instruction in the same cycle.
- Reset mid-HALT returns to RUN on the next edge.
- `icount` wrap: at 2^CNT_W−1 the next RUN edge gives 0. No flag is raised.
- An ALU op with `z`=1 followed by LI: `zflag` stays 1, because LI has `wez`=0.

## Test plan
- **Reset**: hold `reset` for 2 cycles with `Opcode`=000001 → `we3`=0, `wez`=0; after release `zflag`=0, `icount`=0, `halted`=0, `illegal`=0.
- **ALU, LI and flag load**:
  - `Opcode`=001100 (`Op`=011) with `z`=1 → `we3`=1, `wez`=1, `Op`=011; next cycle `zflag`=1.
  - Then `Opcode`=100011 → `s_inm`=1, `we3`=1, `wez`=0; `zflag` stays 1.
- **Conditional jumps**:
  - With `zflag`=1: JZ gives `s_inc`=0 and JNZ gives `s_inc`=1.
  - After an ALU op with `z`=0: JZ gives `s_inc`=1 and JNZ gives `s_inc`=0.
  - J always gives `s_inc`=0.
- **Halt**:
  - After 5 instructions, `Opcode`=101111 → `s_inc`=0; next cycle `halted`=1 and `icount`=6.
  - Drive ALU opcodes for 10 cycles → `we3`=0 and `icount`=6 throughout.
  - Pulse `reset` → `halted`=0, `icount`=0.
- **Illegal opcode**: `Opcode`=110101 → all defaults (`s_inc`=1, no writes); `illegal`=1 next cycle and stays 1 through 20 legal instructions until `reset`.
- **Counter wrap**: with `CNT_W`=4, run 17 NOPs (100100, reserved) → `icount` reads 1.
